unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the fetch stage (IF) and the load/store stage (DM) of the RISCV core.
- Sequences each access as a multi-cycle request/ack transaction and returns data to the winning requester with a one-cycle ready pulse.
- The core stalls each stage while its req is high and ready is low.
- Data accesses have priority; a streak limit prevents fetch starvation; a watchdog aborts hung transactions.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- MAX_DM_STREAK, 4, consecutive DM grants allowed while IF waits before IF is forced through (minimum 1).
- TIMEOUT, 255, cycles in BUSY without mem_ack before abort; 0 disables the watchdog.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; valid with if_ready.
- if_ready  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1 = store.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_wstrb  in  DATA_W/8  byte enables for stores.
- dm_rdata  out  DATA_W  load data; valid with dm_ready.
- dm_ready  out  1  one-cycle completion pulse for data.
- mem_req  out  1  memory request; level, held until mem_ack.
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion from memory.
- err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- FSM states: IDLE, BUSY, RESP. A grant register records the owner (IF or DM).
- Reset (async, immediate): state IDLE, mem_req=0, all mem_* fields 0, if_ready=dm_ready=0, if_rdata=dm_rdata=0, err=0, streak=0, watchdog=0.
- Reset asserted mid-transaction drops mem_req at once. A late mem_ack arriving after reset is ignored.
- IDLE, arbitration:
  - dm_req and (streak<MAX_DM_STREAK or !if_req): grant DM.
  - else if if_req: grant IF.
  - On grant: latch the owner's addr/we/wdata/wstrb into the mem_* registers. IF grants always have we=0 and wstrb=0.
  - Next state is BUSY; no grant means stay in IDLE.
- Streak counter:
  - Increments on a DM grant while if_req=1 (saturating).
  - Clears on an IF grant or whenever if_req=0 in IDLE.
- BUSY:
  - mem_req=1 with stable fields.
  - On mem_ack: capture mem_rdata into the owner's rdata register and go to RESP; mem_req falls the same edge.
  - mem_ack in IDLE or RESP is ignored.
- RESP: the owner's ready=1 for exactly one cycle, then IDLE.
- Requester contract: deassert or change req in the cycle after ready. Because of RESP, the arbiter never re-grants the completed request.
- Latency: req seen in IDLE at cycle 0, mem_req at cycle 1, ready at cycle N+1, where N is the cycle mem_ack arrives (N≥1). Minimum is 2 cycles req→ready; throughput is one access per 3 cycles.
- rdata holds its value until the next completion for that port.
- Stores still complete with a ready pulse; rdata is then loaded with mem_rdata (don't-care for the core).
- Watchdog: counts cycles in BUSY. When the count reaches TIMEOUT with no ack:
  - drop mem_req, pulse err, go to RESP;
  - the owner gets ready with rdata=0.
  - The counter clears on leaving BUSY.
- Simultaneous mem_ack and timeout in the same cycle: the ack wins, with no err.
- Requests that arrive during BUSY/RESP wait; none are lost, since req is level-held.

Decomposition:
- Shared header/package riscv_mem_defs: state encodings (IDLE=0, BUSY=1, RESP=2), grant encodings (GNT_IF=0, GNT_DM=1), default TIMEOUT/MAX_DM_STREAK.
- One sub-module, mem_watchdog: a loadable/clearable counter with enable, a TIMEOUT parameter and an expire output (zero-disables).

Test Plan:
- rst pulse during BUSY with mem_req=1 -> mem_req=0 in the same cycle, state IDLE; an ack 2 cycles later produces no ready.
- IF only, if_addr=0x00000010, memory acks 1 cycle after mem_req with 0x00A00093 -> mem_addr=0x10, mem_we=0; if_ready pulses 1 cycle with if_rdata=0x00A00093, 2 cycles after grant.
- Both req together, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, wstrb=0xF -> DM served first (mem_we=1, fields match), dm_ready pulses, then IF is granted.
- dm_req held high continuously with if_req high, MAX_DM_STREAK=4 -> exactly 4 DM grants, then 1 IF grant, then DM resumes; streak resets.
- Memory never acks, TIMEOUT=8 -> mem_req falls after 8 BUSY cycles, err and dm_ready pulse together, dm_rdata=0.
- mem_ack asserted in the same cycle the watchdog expires -> normal completion with rdata captured and err=0; a stray mem_ack in IDLE -> no ready pulse.

Source files
------------

// File: rtl/riscv_mem_defs.sv
// Shared encodings for the unified instruction/data memory arbiter.
// Latency: n/a (definitions only). Backpressure: n/a.
package riscv_mem_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_t;

  localparam int DEF_TIMEOUT       = 255;
  localparam int DEF_MAX_DM_STREAK = 4;

endpackage

// File: rtl/mem_watchdog.sv
// Counts enabled cycles and flags expiry on the TIMEOUT-th one; TIMEOUT=0 never expires.
// Latency: expire is combinational from the count. Backpressure: none, holds at expiry until cleared.
module mem_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] cnt_q;

  // The first enabled cycle sees a count of 0, so expiry lands on cycle TIMEOUT.
  assign expire = (TIMEOUT > 0) && en && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported memory between fetch (IF) and load/store (DM), DM first with a streak cap.
// Latency: ready two or more cycles after req is seen in IDLE. Backpressure: requesters stall on held req until ready.
module unified_mem_arbiter
  import riscv_mem_defs::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                err
);

  localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  state_t              state_q, state_d;
  gnt_t                gnt_q, gnt_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                grant;
  logic                busy;
  logic                wd_expire;
  logic                done;

  assign busy    = (state_q == BUSY);
  assign mem_req = busy;
  assign done    = busy && (mem_ack || wd_expire);

  mem_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (!busy),
    .en    (busy),
    .expire(wd_expire)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    streak_d = streak_q;
    grant    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_req && ((streak_q < STREAK_MAX) || !if_req)) begin
          grant   = 1'b1;
          gnt_d   = GNT_DM;
          state_d = BUSY;
          // Only DM wins that keep IF waiting count toward the streak.
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
          end
        end else begin
          streak_d = '0;
          if (if_req) begin
            grant   = 1'b1;
            gnt_d   = GNT_IF;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (mem_ack || wd_expire) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_IF;
      streak_q  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      streak_q <= streak_d;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      err      <= 1'b0;
      if (grant) begin
        if (gnt_d == GNT_DM) begin
          mem_we    <= dm_we;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
          mem_wstrb <= dm_wstrb;
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          mem_wstrb <= '0;
        end
      end
      // An ack in the expiry cycle still counts as a normal completion.
      if (done) begin
        err <= !mem_ack;
        if (gnt_q == GNT_DM) begin
          dm_ready <= 1'b1;
          dm_rdata <= mem_ack ? mem_rdata : '0;
        end else begin
          if_ready <= 1'b1;
          if_rdata <= mem_ack ? mem_rdata : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: transaction-level model checked every cycle plus literal pins.
module tb_unified_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [3:0]    dm_wstrb = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack;
  logic          err;

  unified_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_DM_STREAK(MAXS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: acks on the (resp_lat+1)-th cycle of mem_req; resp_lat<0 never acks.
  int            resp_lat = 0;
  logic [DW-1:0] resp_data = '0;
  int            busy_n = 0;
  logic          resp_ack = 1'b0;
  logic          stray_ack = 1'b0;
  int            req_cycles = 0;
  assign mem_ack = resp_ack | stray_ack;

  always @(negedge clk) begin
    if (rst || !mem_req) begin
      busy_n   = 0;
      resp_ack = 1'b0;
    end else begin
      busy_n++;
      resp_ack  = (resp_lat >= 0) && (busy_n == resp_lat + 1);
      mem_rdata = resp_data;
    end
    if (mem_req) req_cycles++;
  end

  // Transaction-level model of what the outputs must show in each cycle.
  bit            m_act, m_resp, m_dm, m_ifr, m_dmr, m_err, m_we;
  int            m_age, m_streak;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_rdata, m_dm_rdata, m_ret;
  logic [3:0]    m_wstrb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_resp = 0; m_dm = 0; m_ifr = 0; m_dmr = 0; m_err = 0; m_we = 0;
      m_age = 0; m_streak = 0;
      m_addr = '0; m_wdata = '0; m_wstrb = '0; m_if_rdata = '0; m_dm_rdata = '0;
    end else begin
      m_ifr = 0; m_dmr = 0; m_err = 0;
      if (m_resp) begin
        m_resp = 0;
      end else if (m_act) begin
        m_age++;
        if (mem_ack || (TO != 0 && m_age >= TO)) begin
          m_ret = mem_ack ? mem_rdata : '0;
          if (m_dm) begin m_dm_rdata = m_ret; m_dmr = 1; end
          else begin m_if_rdata = m_ret; m_ifr = 1; end
          m_err  = !mem_ack;
          m_act  = 0;
          m_resp = 1;
        end
      end else if (dm_req && (m_streak < MAXS || !if_req)) begin
        m_act = 1; m_dm = 1; m_age = 0;
        m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata; m_wstrb = dm_wstrb;
        m_streak = if_req ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
      end else begin
        if (if_req) begin
          m_act = 1; m_dm = 0; m_age = 0;
          m_addr = if_addr; m_we = 0; m_wdata = '0; m_wstrb = '0;
        end
        m_streak = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("mem_req", mem_req, m_act);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_we", mem_we, m_we);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("mem_wstrb", mem_wstrb, m_wstrb);
    chk("if_ready", if_ready, m_ifr);
    chk("dm_ready", dm_ready, m_dmr);
    chk("err", err, m_err);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("dm_rdata", dm_rdata, m_dm_rdata);
  end

  task automatic wait_ready(input bit is_dm, input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_dm ? dm_ready : if_ready) && n < bound);
    chk(is_dm ? "dm_ready_wait" : "if_ready_wait", is_dm ? dm_ready : if_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int    n;
    string glog;
    glog = "";

    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_dm_ready", dm_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // IF alone, memory acks one cycle after mem_req rises.
    resp_lat = 1; resp_data = 32'h00A00093;
    if_addr = 32'h10; if_req = 1'b1;
    @(negedge clk);
    chk("a_mem_req", mem_req, 1);
    chk("a_mem_addr", mem_addr, 32'h10);
    chk("a_mem_we", mem_we, 0);
    wait_ready(0, 10, n);
    chk("a_latency", n + 1, 3);
    chk("a_if_rdata", if_rdata, 32'h00A00093);
    if_req = 1'b0;
    @(negedge clk);
    chk("a_if_ready_pulse", if_ready, 0);

    // DM store and IF together: DM first, IF next.
    resp_lat = 0; resp_data = 32'h11112222;
    dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF; dm_wstrb = 4'hF;
    if_addr = 32'h20;
    dm_req = 1'b1; if_req = 1'b1;
    @(negedge clk);
    chk("b_mem_we", mem_we, 1);
    chk("b_mem_addr", mem_addr, 32'h100);
    chk("b_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("b_mem_wstrb", mem_wstrb, 4'hF);
    wait_ready(1, 10, n);
    chk("b_if_not_first", if_ready, 0);
    dm_req = 1'b0; dm_we = 1'b0;
    wait_ready(0, 10, n);
    chk("b_if_addr", mem_addr, 32'h20);
    chk("b_if_rdata", if_rdata, 32'h11112222);
    if_req = 1'b0;
    @(negedge clk);

    // Both held: four DM grants, one forced IF grant, repeat.
    resp_lat = 0; resp_data = 32'h0BADF00D;
    dm_addr = 32'h300; if_addr = 32'h40;
    dm_req = 1'b1; if_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dm_ready) glog = {glog, "D"};
      if (if_ready) glog = {glog, "I"};
      if (glog.len() >= 10) break;
    end
    dm_req = 1'b0; if_req = 1'b0;
    checks++;
    if (glog != "DDDDIDDDDI") begin
      failures++;
      $display("FAIL c_grant_order: got %s expected DDDDIDDDDI", glog);
    end
    @(negedge clk);

    // Memory never acks: abort after TO busy cycles.
    req_cycles = 0;
    resp_lat = -1; resp_data = 32'hCAFEF00D;
    dm_addr = 32'h200; dm_req = 1'b1;
    wait_ready(1, 30, n);
    chk("d_err", err, 1);
    chk("d_dm_rdata", dm_rdata, 0);
    chk("d_busy_cycles", req_cycles, TO);
    dm_req = 1'b0;
    @(negedge clk);

    // Ack lands in the expiry cycle: normal completion.
    req_cycles = 0;
    resp_lat = TO - 1; resp_data = 32'h12345678;
    dm_addr = 32'h204; dm_req = 1'b1;
    wait_ready(1, 30, n);
    chk("e_err", err, 0);
    chk("e_dm_rdata", dm_rdata, 32'h12345678);
    chk("e_busy_cycles", req_cycles, TO);
    dm_req = 1'b0;
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("e_stray_ready", {if_ready, dm_ready}, 0);
    end

    // Reset mid-transaction, then a late ack.
    resp_lat = -1;
    if_addr = 32'h80; if_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("f_busy", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("f_async_mem_req", mem_req, 0);
    chk("f_async_mem_addr", mem_addr, 0);
    if_req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("f_late_ack_ready", {if_ready, dm_ready}, 0);
    end

    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
